// File: rtl/rlbp_serial_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rlbp_serial_rx_if                                               |
// | Brief    : Wishbone slave bundle for the RLBP serial receiver               |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface rlbp_serial_rx_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface
`default_nettype wire

// File: rtl/rlbp_serial_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rlbp_serial_rx                                                  |
// | Brief    : Deframes the RLBP serial stream into a FIFO read over Wishbone. |
// |            Optional even-parity bit enabled by macro RLBP_RX_PARITY_EN.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module rlbp_serial_rx #(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0100,
  parameter int          CLKS_PER_BIT = 4,
  parameter int          DATA_W       = 8,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  rlbp_serial_rx_if.slave wb,
  input  logic           serial_in,
  output logic           irq
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [AW-1:0]    PTR_LAST = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0]    CNT_MAX  = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  logic              sync1_q, sync2_q;
  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              push_q, push_d;
  logic [DATA_W-1:0] push_data_q;
  logic              en_q, irq_en_q;
  logic              ovf_q, ferr_q, perr_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              ack_q;
  logic [31:0]       dat_q;
  logic              irq_q;

  logic              w_line;
  logic              w_ferr_set, w_perr_set;
  logic              w_empty, w_full;
  logic              w_req, w_hit_data, w_hit_status, w_hit_ctrl, w_acc;
  logic              w_ctrl_wr, w_flush, w_pop, w_wr, w_ovf_set;
  logic [31:0]       w_count32, w_status, w_rdata;
  logic              w_unused_bits;

`ifdef RLBP_RX_PARITY_EN
  logic              parbad_q, parbad_d;
`endif

  assign w_line = sync2_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
    end
  end

  // cnt_q counts down to the next mid-bit sample point.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    push_d     = 1'b0;
    w_ferr_set = 1'b0;
    w_perr_set = 1'b0;
`ifdef RLBP_RX_PARITY_EN
    parbad_d   = parbad_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (w_line) begin
          cnt_d   = CNT_HALF;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (w_line) begin
            cnt_d   = CNT_FULL;
            idx_d   = '0;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d = DATA_W'({shift_q, w_line});
          cnt_d   = CNT_FULL;
          if (idx_q == IDX_LAST) begin
`ifdef RLBP_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef RLBP_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == '0) begin
          parbad_d   = (^shift_q) ^ w_line;
          w_perr_set = (^shift_q) ^ w_line;
          cnt_d      = CNT_FULL;
          state_d    = S_STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == '0) begin
          if (!w_line) begin
`ifdef RLBP_RX_PARITY_EN
            push_d = ~parbad_q;
`else
            push_d = 1'b1;
`endif
            state_d = S_IDLE;
          end else begin
            w_ferr_set = 1'b1;
            state_d    = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (!w_line) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!en_q) begin
      state_d    = S_IDLE;
      push_d     = 1'b0;
      w_ferr_set = 1'b0;
      w_perr_set = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
`ifdef RLBP_RX_PARITY_EN
      parbad_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      push_q  <= push_d;
      if (push_d) push_data_q <= shift_q;
`ifdef RLBP_RX_PARITY_EN
      parbad_q <= parbad_d;
`endif
    end
  end

  assign w_req        = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q;
  assign w_hit_data   = (wb.wbs_adr_i == BASE_ADDR);
  assign w_hit_status = (wb.wbs_adr_i == BASE_ADDR + 32'h4);
  assign w_hit_ctrl   = (wb.wbs_adr_i == BASE_ADDR + 32'h8);
  assign w_acc        = w_req & (w_hit_data | w_hit_status | w_hit_ctrl);
  assign w_ctrl_wr    = w_acc & wb.wbs_we_i & w_hit_ctrl & wb.wbs_sel_i[0];
  assign w_flush      = w_ctrl_wr & wb.wbs_dat_i[2];

  assign w_empty   = (count_q == '0);
  assign w_full    = (count_q == CNT_MAX);
  assign w_pop     = w_acc & ~wb.wbs_we_i & w_hit_data & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr      = push_q & ~w_flush & (~w_full | w_pop);
  assign w_ovf_set = push_q & ~w_flush & w_full & ~w_pop;

  assign w_count32 = 32'(count_q);
  assign w_status  = {16'h0, w_count32[7:0], 3'b000, perr_q, ferr_q, ovf_q, w_full, w_empty};

  always_comb begin
    w_rdata = '0;
    if (w_hit_data && !w_empty) w_rdata = 32'(mem_q[rd_ptr_q]);
    else if (w_hit_status)      w_rdata = w_status;
    else if (w_hit_ctrl)        w_rdata = {30'h0, irq_en_q, en_q};
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_wr) mem_q[wr_ptr_q] <= push_data_q;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
      perr_q   <= 1'b0;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (w_flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        ovf_q    <= 1'b0;
        ferr_q   <= 1'b0;
        perr_q   <= 1'b0;
      end else begin
        if (w_wr)  wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        if (w_pop) rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        count_q <= count_q + CW'(w_wr) - CW'(w_pop);
        if (w_ovf_set)  ovf_q  <= 1'b1;
        if (w_ferr_set) ferr_q <= 1'b1;
        if (w_perr_set) perr_q <= 1'b1;
      end
      if (w_ctrl_wr) begin
        en_q     <= wb.wbs_dat_i[0];
        irq_en_q <= wb.wbs_dat_i[1];
      end
      ack_q <= w_acc;
      dat_q <= (w_acc && !wb.wbs_we_i) ? w_rdata : '0;
      irq_q <= irq_en_q & (~w_empty | ovf_q | ferr_q | perr_q);
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign irq          = irq_q;

  assign w_unused_bits = ^{wb.wbs_sel_i[3:1], wb.wbs_dat_i[31:3], w_count32[31:8]};

endmodule
`default_nettype wire

// File: tb/tb_rlbp_serial_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rlbp_serial_rx                                               |
// | Brief    : Random and directed bench for rlbp_serial_rx with a queue model |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_rlbp_serial_rx;
  localparam logic [31:0] BASE = 32'h3000_0100;
  localparam int CPB   = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic serial;
  logic irq;
  rlbp_serial_rx_if wb();

  rlbp_serial_rx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (wb),
    .serial_in(serial),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Behavioural model: frame-level queue plus flags.
  logic [DW-1:0] q_m[$];
  bit m_en, m_irq_en, m_ovf, m_ferr, m_perr;
  int n_cmp = 0, n_fail = 0;

  bit          exp_valid = 0, exp_rd = 0;
  logic [31:0] exp_dat = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (wb.wbs_ack_o === 1'b1) begin
      chk("ack_expected", {31'h0, exp_valid}, 32'h1);
      if (exp_valid && exp_rd) chk("rd_data", wb.wbs_dat_o, exp_dat);
      exp_valid = 0;
    end else begin
      chk("dat_idle_zero", wb.wbs_dat_o, 32'h0);
    end
  end

  function automatic logic [31:0] m_status();
    int n = q_m.size();
    return {16'h0, 8'(n), 3'b000, m_perr, m_ferr, m_ovf, (n == DEPTH), (n == 0)};
  endfunction

  task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] wdat,
                      input logic [3:0] sel, input bit expect_ack, output logic [31:0] rdata);
    bit got = 0;
    logic [31:0] off = adr - BASE;
    rdata = '0;
    exp_rd = !we;
    exp_dat = '0;
    if (!we) begin
      if (off == 0)      exp_dat = (q_m.size() != 0) ? 32'(q_m[0]) : 32'h0;
      else if (off == 4) exp_dat = m_status();
      else if (off == 8) exp_dat = {30'h0, m_irq_en, m_en};
    end
    exp_valid = expect_ack;
    @(posedge clk); #1;
    wb.wbs_stb_i = 1; wb.wbs_cyc_i = 1; wb.wbs_we_i = we;
    wb.wbs_adr_i = adr; wb.wbs_dat_i = wdat; wb.wbs_sel_i = sel;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (wb.wbs_ack_o) begin got = 1; rdata = wb.wbs_dat_o; break; end
    end
    if (got) begin @(negedge clk); #1; end
    wb.wbs_stb_i = 0; wb.wbs_cyc_i = 0; wb.wbs_we_i = 0;
    chk(expect_ack ? "ack_seen" : "no_ack", {31'h0, got}, {31'h0, expect_ack});
    exp_valid = 0;
    if (expect_ack && got) begin
      if (!we && off == 0 && q_m.size() != 0) void'(q_m.pop_front());
      if (we && off == 8 && sel[0]) begin
        m_en = wdat[0]; m_irq_en = wdat[1];
        if (wdat[2]) begin q_m.delete(); m_ovf = 0; m_ferr = 0; m_perr = 0; end
      end
    end
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] v);
    xfer(0, BASE + off, 32'h0, 4'hF, 1, v);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] v;
    xfer(1, BASE + off, d, sel, 1, v);
  endtask

  task automatic drive_bit(input logic b);
    serial = b;
    repeat (CPB) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input bit stop, input bit par_flip, input int gap_bits);
    bit bad_par = 0;
    @(posedge clk); #1;
    drive_bit(1'b1);
    for (int i = DW - 1; i >= 0; i--) drive_bit(d[i]);
`ifdef RLBP_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
    bad_par = par_flip;
`endif
    drive_bit(stop);
    for (int i = 0; i < gap_bits; i++) drive_bit(1'b0);
    if (m_en) begin
      if (bad_par) m_perr = 1;
      if (stop) m_ferr = 1;
      else if (!bad_par) begin
        if (q_m.size() == DEPTH) m_ovf = 1;
        else q_m.push_back(d);
      end
    end
  endtask

  task automatic glitch();
    @(posedge clk); #1;
    serial = 1'b1;
    @(posedge clk); #1;
    serial = 1'b0;
    repeat (4 * CPB) @(posedge clk);
    #1;
  endtask

  task automatic check_irq();
    repeat (2) @(posedge clk);
    #1;
    chk("irq_model", {31'h0, irq},
        {31'h0, m_irq_en & ((q_m.size() != 0) | m_ovf | m_ferr | m_perr)});
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    rst = 1; serial = 0;
    wb.wbs_stb_i = 0; wb.wbs_cyc_i = 0; wb.wbs_we_i = 0;
    wb.wbs_sel_i = 0; wb.wbs_adr_i = 0; wb.wbs_dat_i = 0;
    m_en = 0; m_irq_en = 0; m_ovf = 0; m_ferr = 0; m_perr = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_ack", {31'h0, wb.wbs_ack_o}, 32'h0);
    chk("rst_dat", wb.wbs_dat_o, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rst = 0;
    rd(4, v); chk("rst_status", v, 32'h0000_0001);
    rd(8, v); chk("rst_ctrl", v, 32'h0);

    // Single frame
    wr(8, 32'h1, 4'hF);
    send_frame(8'hA5, 0, 0, 2);
    rd(4, v); chk("status_one", v, 32'h0000_0100);
    rd(0, v); chk("data_a5", v, 32'h0000_00A5);
    rd(4, v); chk("status_empty", v, 32'h0000_0001);

    // Overflow
    for (int i = 1; i <= 9; i++) send_frame(DW'(i), 0, 0, 2);
    rd(4, v); chk("status_ovf", v, 32'h0000_0806);
    for (int i = 1; i <= 8; i++) begin rd(0, v); chk("data_seq", v, 32'(i)); end
    rd(0, v); chk("data_empty_read", v, 32'h0);
    rd(4, v); chk("status_ovf_sticky", v, 32'h0000_0005);
    wr(8, 32'h5, 4'hF);
    rd(4, v); chk("status_flushed", v, 32'h0000_0001);
    rd(8, v); chk("ctrl_flush_selfclr", v, 32'h1);

    // Framing error then recovery
    send_frame(8'h3C, 1, 0, 4);
    rd(4, v); chk("status_ferr", v, 32'h0000_0009);
    send_frame(8'h55, 0, 0, 2);
    rd(0, v); chk("data_55", v, 32'h0000_0055);
    wr(8, 32'h5, 4'hF);

    // One-cycle glitch
    glitch();
    rd(4, v); chk("status_glitch", v, 32'h0000_0001);

    // Interrupts
    wr(8, 32'h3, 4'hF);
    send_frame(8'h7E, 0, 0, 2);
    chk("irq_after_push", {31'h0, irq}, 32'h1);
    rd(0, v); chk("data_7e", v, 32'h0000_007E);
    repeat (2) @(posedge clk);
    #1;
    chk("irq_after_pop", {31'h0, irq}, 32'h0);
    for (int i = 0; i < 9; i++) send_frame(8'hC0 + DW'(i), 0, 0, 2);
    chk("irq_overflow", {31'h0, irq}, 32'h1);
    wr(8, 32'h4, 4'hF);
    rd(4, v); chk("status_after_flush", v, 32'h0000_0001);
    repeat (2) @(posedge clk);
    #1;
    chk("irq_after_flush", {31'h0, irq}, 32'h0);

    // Byte-select, unmapped addresses, writes to RO registers
    wr(8, 32'h1, 4'hF);
    wr(8, 32'h0, 4'hE);
    rd(8, v); chk("ctrl_sel_ignored", v, 32'h1);
    xfer(0, BASE + 32'hC, 32'h0, 4'hF, 0, v);
    xfer(0, BASE + 32'h100, 32'h0, 4'hF, 0, v);
    send_frame(8'h11, 0, 0, 2);
    wr(0, 32'hFF, 4'hF);
    wr(4, 32'hFF, 4'hF);
    rd(0, v); chk("data_11", v, 32'h0000_0011);

`ifdef RLBP_RX_PARITY_EN
    send_frame(8'h0F, 0, 1, 2);
    rd(4, v); chk("status_perr", v, 32'h0000_0011);
    wr(8, 32'h5, 4'hF);
    send_frame(8'h0F, 0, 0, 2);
    rd(0, v); chk("data_0f_parity", v, 32'h0000_000F);
`endif

    // Random traffic against the model
    wr(8, 32'h3, 4'hF);
    for (int it = 0; it < 250; it++) begin
      int r = $urandom_range(0, 99);
      if (r < 55) begin
        bit stop = ($urandom_range(0, 9) == 0);
        bit flip = 0;
`ifdef RLBP_RX_PARITY_EN
        flip = ($urandom_range(0, 9) == 0);
`endif
        send_frame(DW'($urandom), stop, flip, $urandom_range(2, 3));
      end else if (r < 88) begin
        rd(32'(4 * $urandom_range(0, 2)), v);
      end else if (r < 93) begin
        glitch();
      end else begin
        logic [31:0] d = {29'h0, ($urandom_range(0, 3) == 0), 1'b1, ($urandom_range(0, 4) != 0)};
        d[1] = $urandom_range(0, 1);
        wr(8, d, 4'hF);
      end
      check_irq();
    end
    rd(4, v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
